// File: rtl/signal_gen_pkg.sv
// signal_gen_pkg
// Shared types and constants for the waveform sample generator.
//   state_e : controller state as reported on sts_state (IDLE/RUN/DONE).
//   mode_e  : waveform shape selected by ctrl[1].
//   CTRL_*  : bit positions inside the ctrl register.
package signal_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        SAW = 1'b0,
        TRI = 1'b1
    } mode_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE    = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_CLR     = 3;

endpackage

// File: rtl/signal_gen_tick.sv
// signal_gen_tick
// Sample-tick generator: a period down-counter that fires on the first cycle
// of a run and then once every `period` clocks (period 0 behaves like 1).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : high while the generator is in RUN; the count restarts when it rises
//   period     : clocks per tick
//   tick       : one-cycle tick pulse
module signal_gen_tick #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] reload_s;

    // Reload value: period 0 and period 1 both mean "tick every clock".
    always_comb begin
        if (period == {CNT_W{1'b0}}) begin
            reload_s = {CNT_W{1'b0}};
        end else begin
            reload_s = period - CNT_W'(1);
        end
    end

    // Counter is held at zero outside RUN so the first running cycle ticks.
    always_comb begin
        tick  = run && (cnt_q == {CNT_W{1'b0}});
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == {CNT_W{1'b0}}) begin
            cnt_d = reload_s;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/signal_gen_core.sv
// signal_gen_core
// Sawtooth / triangle sample generator fed by the signal_ip AXI4-Lite
// register file. Configuration is captured into shadow registers when a run
// starts; samples leave through a valid/ready master port; state and
// counters are returned for register readback.
// Optional feature macro: SIGNAL_GEN_IRQ_EN adds the irq output (one-cycle
// pulse on each wrap event and on entry to DONE).
// Ports:
//   s00_axi_aclk, s00_axi_aresetn : clock, asynchronous active-low reset
//   cfg_ctrl   : [0] enable, [1] mode (0 saw / 1 tri), [2] oneshot, [3] clr_cnt
//   cfg_period : clocks per sample tick (0 treated as 1)
//   cfg_step   : accumulator increment
//   cfg_limit  : peak value
//   m_tdata, m_tvalid, m_tready : sample stream
//   sts_state, sts_sample_cnt, sts_drop_cnt : status readback
//   irq        : interrupt pulse (SIGNAL_GEN_IRQ_EN only)
module signal_gen_core
    import signal_gen_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    input  logic [31:0]       cfg_ctrl,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [DATA_W-1:0] cfg_step,
    input  logic [DATA_W-1:0] cfg_limit,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [1:0]        sts_state,
    output logic [CNT_W-1:0]  sts_sample_cnt,
    output logic [DROP_W-1:0] sts_drop_cnt
`ifdef SIGNAL_GEN_IRQ_EN
    ,
    output logic              irq
`endif
);

    state_e            state_q,      state_d;
    logic [DATA_W-1:0] acc_q,        acc_d;
    logic              dir_down_q,   dir_down_d;
    logic [CNT_W-1:0]  sh_period_q,  sh_period_d;
    logic [DATA_W-1:0] sh_step_q,    sh_step_d;
    logic [DATA_W-1:0] sh_limit_q,   sh_limit_d;
    mode_e             sh_mode_q,    sh_mode_d;
    logic              sh_oneshot_q, sh_oneshot_d;
    logic [DATA_W-1:0] tdata_q,      tdata_d;
    logic              tvalid_q,     tvalid_d;
    logic [CNT_W-1:0]  scnt_q,       scnt_d;
    logic [DROP_W-1:0] dcnt_q,       dcnt_d;

    logic              en_s;
    logic              clr_s;
    logic              run_s;
    logic              tick_s;
    logic              slot_free_s;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W-1:0] adv_acc_s;
    logic              adv_dir_s;
    logic              adv_wrap_s;
    logic              wrap_evt_s;
    logic              done_entry_s;
    logic              drop_s;
    logic              unused_ctrl_s;

    assign en_s          = cfg_ctrl[CTRL_EN];
    assign clr_s         = cfg_ctrl[CTRL_CLR];
    assign run_s         = (state_q == RUN);
    assign slot_free_s   = !tvalid_q || m_tready;
    assign unused_ctrl_s = ^cfg_ctrl[31:4];

    signal_gen_tick #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk    (s00_axi_aclk),
        .rst_n  (s00_axi_aresetn),
        .run    (run_s),
        .period (sh_period_q),
        .tick   (tick_s)
    );

    // Accumulator advance for the current shadow configuration. The sum is
    // one bit wider so a saw overshoot past the limit is never masked by wrap.
    always_comb begin
        sum_s      = {1'b0, acc_q} + {1'b0, sh_step_q};
        adv_acc_s  = acc_q;
        adv_dir_s  = dir_down_q;
        adv_wrap_s = 1'b0;
        if (sh_step_q == {DATA_W{1'b0}}) begin
            // A zero step freezes the waveform; no wrap is ever reported.
            adv_acc_s = acc_q;
        end else if (sh_mode_q == SAW) begin
            if (sum_s > {1'b0, sh_limit_q}) begin
                adv_acc_s  = {DATA_W{1'b0}};
                adv_wrap_s = 1'b1;
            end else begin
                adv_acc_s = sum_s[DATA_W-1:0];
            end
        end else if (!dir_down_q) begin
            // Clamping at the peak turns the ramp around without a wrap.
            if (sum_s >= {1'b0, sh_limit_q}) begin
                adv_acc_s = sh_limit_q;
                adv_dir_s = 1'b1;
            end else begin
                adv_acc_s = sum_s[DATA_W-1:0];
            end
        end else begin
            if (acc_q <= sh_step_q) begin
                adv_acc_s  = {DATA_W{1'b0}};
                adv_dir_s  = 1'b0;
                adv_wrap_s = 1'b1;
            end else begin
                adv_acc_s = acc_q - sh_step_q;
            end
        end
    end

    // Controller next state, sample slot and counters.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        dir_down_d   = dir_down_q;
        sh_period_d  = sh_period_q;
        sh_step_d    = sh_step_q;
        sh_limit_d   = sh_limit_q;
        sh_mode_d    = sh_mode_q;
        sh_oneshot_d = sh_oneshot_q;
        tdata_d      = tdata_q;
        // A held sample drops once accepted, whatever state we are in.
        tvalid_d     = tvalid_q && !m_tready;
        wrap_evt_s   = 1'b0;
        done_entry_s = 1'b0;
        drop_s       = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_s) begin
                    state_d      = RUN;
                    sh_period_d  = cfg_period;
                    sh_step_d    = cfg_step;
                    sh_limit_d   = cfg_limit;
                    sh_mode_d    = mode_e'(cfg_ctrl[CTRL_MODE]);
                    sh_oneshot_d = cfg_ctrl[CTRL_ONESHOT];
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!en_s) begin
                    state_d    = IDLE;
                    acc_d      = {DATA_W{1'b0}};
                    dir_down_d = 1'b0;
                end else if (tick_s) begin
                    if (slot_free_s) begin
                        tdata_d    = acc_q;
                        tvalid_d   = 1'b1;
                        acc_d      = adv_acc_s;
                        dir_down_d = adv_dir_s;
                        wrap_evt_s = adv_wrap_s;
                        if (adv_wrap_s && sh_oneshot_q) begin
                            state_d      = DONE;
                            done_entry_s = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        // Backpressured tick: sample lost, waveform frozen.
                        drop_s = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (!en_s) begin
                    state_d    = IDLE;
                    acc_d      = {DATA_W{1'b0}};
                    dir_down_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d    = IDLE;
                acc_d      = {DATA_W{1'b0}};
                dir_down_d = 1'b0;
            end
        endcase

        // Clear has priority over any increment in the same cycle.
        if (clr_s) begin
            scnt_d = {CNT_W{1'b0}};
            dcnt_d = {DROP_W{1'b0}};
        end else begin
            scnt_d = scnt_q + CNT_W'(tvalid_q && m_tready);
            if (drop_s && (dcnt_q != {DROP_W{1'b1}})) begin
                dcnt_d = dcnt_q + DROP_W'(1);
            end else begin
                dcnt_d = dcnt_q;
            end
        end
    end

    // State, shadow configuration, sample slot and counter registers.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q      <= IDLE;
            acc_q        <= {DATA_W{1'b0}};
            dir_down_q   <= 1'b0;
            sh_period_q  <= {CNT_W{1'b0}};
            sh_step_q    <= {DATA_W{1'b0}};
            sh_limit_q   <= {DATA_W{1'b0}};
            sh_mode_q    <= SAW;
            sh_oneshot_q <= 1'b0;
            tdata_q      <= {DATA_W{1'b0}};
            tvalid_q     <= 1'b0;
            scnt_q       <= {CNT_W{1'b0}};
            dcnt_q       <= {DROP_W{1'b0}};
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            dir_down_q   <= dir_down_d;
            sh_period_q  <= sh_period_d;
            sh_step_q    <= sh_step_d;
            sh_limit_q   <= sh_limit_d;
            sh_mode_q    <= sh_mode_d;
            sh_oneshot_q <= sh_oneshot_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            scnt_q       <= scnt_d;
            dcnt_q       <= dcnt_d;
        end
    end

    assign m_tdata        = tdata_q;
    assign m_tvalid       = tvalid_q;
    assign sts_state      = state_q;
    assign sts_sample_cnt = scnt_q;
    assign sts_drop_cnt   = dcnt_q;

`ifdef SIGNAL_GEN_IRQ_EN
    logic irq_q;
    logic irq_d;

    assign irq_d = wrap_evt_s || done_entry_s;

    // Interrupt pulse register, aligned with the sample that caused it.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_evt_s;
    assign unused_evt_s = wrap_evt_s | done_entry_s;
`endif

endmodule

// File: tb/tb_signal_gen_core.sv
// tb_signal_gen_core
// Self-checking bench for signal_gen_core: directed scenarios plus a random
// phase, compared every cycle against a behavioural model of the generator.
module tb_signal_gen_core;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 32;
    localparam int DROP_W = 4;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic [31:0]       cfg_ctrl   = 32'd0;
    logic [CNT_W-1:0]  cfg_period = '0;
    logic [DATA_W-1:0] cfg_step   = '0;
    logic [DATA_W-1:0] cfg_limit  = '0;
    logic              m_tready   = 1'b0;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic [1:0]        sts_state;
    logic [CNT_W-1:0]  sts_sample_cnt;
    logic [DROP_W-1:0] sts_drop_cnt;
`ifdef SIGNAL_GEN_IRQ_EN
    logic              irq;
`endif

    signal_gen_core #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .DROP_W (DROP_W)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .cfg_ctrl        (cfg_ctrl),
        .cfg_period      (cfg_period),
        .cfg_step        (cfg_step),
        .cfg_limit       (cfg_limit),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .sts_state       (sts_state),
        .sts_sample_cnt  (sts_sample_cnt),
        .sts_drop_cnt    (sts_drop_cnt)
`ifdef SIGNAL_GEN_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Behavioural model: 0 idle, 1 running, 2 done.
    int          m_state;
    int          m_acc;
    bit          m_up;
    bit          m_valid;
    int          m_data;
    int unsigned m_scnt;
    int          m_dcnt;
    bit          m_irq;
    int unsigned m_run_cyc;
    int unsigned sh_period;
    int          sh_step;
    int          sh_limit;
    bit          sh_mode;
    bit          sh_oneshot;

    task automatic model_reset();
        m_state = 0; m_acc = 0; m_up = 1'b1; m_valid = 1'b0; m_data = 0;
        m_scnt = 0; m_dcnt = 0; m_irq = 1'b0; m_run_cyc = 0;
        sh_period = 0; sh_step = 0; sh_limit = 0; sh_mode = 1'b0; sh_oneshot = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit en, free, hs, wrap, drop;
        int unsigned per;
        en   = cfg_ctrl[0];
        hs   = m_valid && m_tready;
        free = !m_valid || m_tready;
        wrap = 1'b0;
        drop = 1'b0;
        m_irq = 1'b0;
        if (hs) m_valid = 1'b0;
        if (m_state == 0) begin
            if (en) begin
                sh_period = cfg_period; sh_step = int'(cfg_step); sh_limit = int'(cfg_limit);
                sh_mode = cfg_ctrl[1]; sh_oneshot = cfg_ctrl[2];
                m_state = 1; m_run_cyc = 0;
            end
        end else if (m_state == 1) begin
            if (!en) begin
                m_state = 0; m_acc = 0; m_up = 1'b1;
            end else begin
                per = (sh_period == 0) ? 1 : sh_period;
                if ((m_run_cyc % per) == 0) begin
                    if (free) begin
                        m_data = m_acc; m_valid = 1'b1;
                        if (sh_step != 0) begin
                            if (!sh_mode) begin
                                if (m_acc + sh_step > sh_limit) begin m_acc = 0; wrap = 1'b1; end
                                else m_acc = m_acc + sh_step;
                            end else if (m_up) begin
                                if (m_acc + sh_step >= sh_limit) begin m_acc = sh_limit; m_up = 1'b0; end
                                else m_acc = m_acc + sh_step;
                            end else begin
                                if (m_acc <= sh_step) begin m_acc = 0; m_up = 1'b1; wrap = 1'b1; end
                                else m_acc = m_acc - sh_step;
                            end
                        end
                        if (wrap) begin
                            m_irq = 1'b1;
                            if (sh_oneshot) m_state = 2;
                        end
                    end else begin
                        drop = 1'b1;
                    end
                end
                m_run_cyc++;
            end
        end else begin
            if (!en) begin
                m_state = 0; m_acc = 0; m_up = 1'b1;
            end
        end
        if (cfg_ctrl[3]) begin
            m_scnt = 0; m_dcnt = 0;
        end else begin
            if (hs) m_scnt = m_scnt + 1;
            if (drop && m_dcnt < (1 << DROP_W) - 1) m_dcnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("tdata",      64'(m_tdata),        64'(m_data));
        chk("tvalid",     64'(m_tvalid),       64'(m_valid));
        chk("state",      64'(sts_state),      64'(m_state));
        chk("sample_cnt", 64'(sts_sample_cnt), 64'(m_scnt));
        chk("drop_cnt",   64'(sts_drop_cnt),   64'(m_dcnt));
`ifdef SIGNAL_GEN_IRQ_EN
        chk("irq",        64'(irq),            64'(m_irq));
`endif
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        cyc_n++;
        check_outputs();
    endtask

    task automatic set_cfg(input bit en, input bit mode, input bit oneshot, input bit clr,
                           input int unsigned per, input int stp, input int lim);
        cfg_ctrl   = {28'd0, clr, oneshot, mode, en};
        cfg_period = CNT_W'(per);
        cfg_step   = DATA_W'(stp);
        cfg_limit  = DATA_W'(lim);
    endtask

    task automatic go_idle(input int n);
        cfg_ctrl[0] = 1'b0;
        m_tready    = 1'b1;
        repeat (n) cyc();
    endtask

    int q[$];
    int qc[$];
    int mx;
    int exp1[6] = '{0, 1, 2, 3, 0, 1};
    int exp2[8] = '{0, 2, 4, 5, 3, 1, 0, 2};

    initial begin
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Saw 0..3, full throughput.
        m_tready = 1'b1;
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 3);
        q.delete();
        repeat (8) begin
            cyc();
            if (m_tvalid) q.push_back(int'(m_tdata));
        end
        chk("t1_count", 64'(q.size() >= 6), 64'd1);
        for (int i = 0; i < 6 && i < q.size(); i++) chk("t1_seq", 64'(q[i]), 64'(exp1[i]));
        go_idle(2);

        // Triangle with clamp at the peak.
        set_cfg(1'b1, 1'b1, 1'b0, 1'b0, 1, 2, 5);
        q.delete();
        repeat (10) begin
            cyc();
            if (m_tvalid) q.push_back(int'(m_tdata));
        end
        chk("t2_count", 64'(q.size() >= 8), 64'd1);
        for (int i = 0; i < 8 && i < q.size(); i++) chk("t2_seq", 64'(q[i]), 64'(exp2[i]));
        go_idle(2);

        // Backpressure: ten lost ticks, then release; later saturate the drop counter.
        set_cfg(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 3);
        cyc();
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 3);
        m_tready = 1'b0;
        repeat (12) cyc();
        chk("t3_drop10", 64'(sts_drop_cnt), 64'd10);
        chk("t3_hold_valid", 64'(m_tvalid), 64'd1);
        chk("t3_hold_data", 64'(m_tdata), 64'd0);
        m_tready = 1'b1;
        cyc();
        chk("t3_next_data", 64'(m_tdata), 64'd1);
        m_tready = 1'b0;
        repeat (20) cyc();
        chk("t3_drop_sat", 64'(sts_drop_cnt), 64'd15);
        go_idle(2);

        // Oneshot saw, period 4.
        m_tready = 1'b1;
        set_cfg(1'b1, 1'b0, 1'b1, 1'b0, 4, 1, 2);
        q.delete(); qc.delete();
        repeat (14) begin
            cyc();
            if (m_tvalid) begin q.push_back(int'(m_tdata)); qc.push_back(cyc_n); end
        end
        chk("t4_count", 64'(q.size()), 64'd3);
        for (int i = 0; i < 3 && i < q.size(); i++) chk("t4_seq", 64'(q[i]), 64'(i));
        for (int i = 1; i < 3 && i < qc.size(); i++) chk("t4_gap", 64'(qc[i] - qc[i-1]), 64'd4);
        chk("t4_done", 64'(sts_state), 64'd2);
        repeat (3) cyc();
        chk("t4_done_hold", 64'(sts_state), 64'd2);
        go_idle(1);
        chk("t4_idle", 64'(sts_state), 64'd0);

        // Limit rewritten mid-run only takes effect on the next run.
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 3);
        repeat (3) cyc();
        cfg_limit = DATA_W'(7);
        mx = 0;
        repeat (12) begin
            cyc();
            if (m_tvalid && int'(m_tdata) > mx) mx = int'(m_tdata);
        end
        chk("t5_old_limit", 64'(mx), 64'd3);
        go_idle(2);
        cfg_ctrl[0] = 1'b1;
        mx = 0;
        repeat (14) begin
            cyc();
            if (m_tvalid && int'(m_tdata) > mx) mx = int'(m_tdata);
        end
        chk("t5_new_limit", 64'(mx), 64'd7);

        // Asynchronous reset while a sample is held.
        m_tready = 1'b0;
        repeat (3) cyc();
        chk("t6_valid_before", 64'(m_tvalid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_tdata", 64'(m_tdata), 64'd0);
        chk("t6_tvalid", 64'(m_tvalid), 64'd0);
        chk("t6_state", 64'(sts_state), 64'd0);
        chk("t6_scnt", 64'(sts_sample_cnt), 64'd0);
        chk("t6_dcnt", 64'(sts_drop_cnt), 64'd0);
`ifdef SIGNAL_GEN_IRQ_EN
        chk("t6_irq", 64'(irq), 64'd0);
`endif
        model_reset();
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 3);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Random configurations, enables, clears and backpressure.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                set_cfg($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3) == 0, 1'b0, $urandom_range(0, 4),
                        ($urandom_range(0, 7) == 0) ? int'($urandom() & 32'hFFFF) : int'($urandom_range(0, 6)),
                        ($urandom_range(0, 7) == 0) ? int'($urandom() & 32'hFFFF) : int'($urandom_range(0, 20)));
            end
            cfg_ctrl[3] = ($urandom_range(0, 39) == 0);
            m_tready    = ($urandom_range(0, 9) < 7);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
